mux_arbiter: RTL
================

Name: mux_arbiter

Overview:
- Round-robin arbiter that shares one registered multiplexer output line between NUM_REQ requesters.
- Drives the mux select (ctrl) and a one-hot grant, and inserts guard cycles after every select change so that the one-cycle registered mux output settles before the new owner is told it holds the line.
- Enforces a programmable minimum hold time before a current owner can be preempted.
- Sits between the requesting trigger/timing sources and the mux select input.

Parameters:
- CTRL_BITS, 2: width of the ctrl output; must match the mux select width.
- NUM_REQ, 4: number of requesters; constraint 2 <= NUM_REQ <= 2^CTRL_BITS.
- HOLD_BITS, 8: width of min_hold and of the internal hold counter.
- GUARD_CYCLES, 2: clock cycles spent in GUARD after a select change; constraint >= 1.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous active-low reset, named as in the rest of the codebase.
- enable  in  1  1 = arbitration allowed; 0 = release the line and accept no new grants.
- req  in  NUM_REQ  request per requester; level-sensitive; held high while ownership is wanted.
- min_hold  in  HOLD_BITS  minimum GRANT cycles before preemption; sampled on entry to GRANT.
- ctrl  out  CTRL_BITS  registered mux select = index of the selected requester.
- grant  out  NUM_REQ  registered one-hot grant; all zero outside GRANT.
- valid  out  1  registered; 1 only in GRANT (mux output belongs to the granted requester).
- busy  out  1  registered; 1 in GUARD or GRANT.

Behaviour:
- Reset (asynchronous, while reset_n=0): state=IDLE, ctrl=0, grant=0, valid=0, busy=0, hold counter=0, guard counter=0, last_idx=NUM_REQ-1 so the first search starts at index 0. Reset asserted mid-operation aborts any GUARD/GRANT immediately; no partial grant survives.
- Round-robin pick: search indices last_idx+1, last_idx+2, ... modulo NUM_REQ. The first index with req=1 (and, in a preemption, not equal to the current owner) wins. last_idx is updated to the winner on every pick.
- IDLE:
  - ctrl holds its last value; grant=0, valid=0, busy=0.
  - At an edge with enable=1 and any req=1: ctrl<=winner, guard counter<=GUARD_CYCLES, go to GUARD.
- GUARD:
  - busy=1, valid=0, grant=0.
  - Each edge decrements the guard counter. The edge seeing counter==1 enters GRANT: grant[ctrl]<=1, valid<=1, hold counter<=min_hold.
  - grant is therefore high GUARD_CYCLES edges after the pick edge.
  - If req[ctrl] drops or enable=0 during GUARD: abort at that edge. Re-pick if enable=1 and another req is pending (new GUARD, counter reloaded); otherwise go to IDLE.
- GRANT:
  - The hold counter decrements each edge, saturating at 0.
  - Release when req[owner]=0 or enable=0: grant/valid drop at that edge.
  - Preempt when hold counter==0 and another req is pending: grant/valid drop at that edge.
  - On release or preemption with enable=1 and another req pending, go directly to GUARD with a new ctrl; otherwise go to IDLE.
  - min_hold=0: the owner gets exactly one GRANT cycle if others are waiting.
  - The owner is considered last in its own preemption search.
- Simultaneous release and new request at the same edge: the pick uses the current-cycle req vector, excluding the releasing owner.
- Invariants:
  - grant is never more than one-hot.
  - valid == |grant.
  - ctrl changes only at edges that enter GUARD, never while valid=1.

Test Plan:
- Reset then req=4'b0100, enable=1, GUARD_CYCLES=2 -> ctrl=2 at edge E0, grant=4'b0100 and valid=1 at E2, busy=1 from E0.
- req=4'b1111 held, min_hold=3 -> ownership order 0,1,2,3,0; each owner holds 4 GRANT cycles, separated by 2 GUARD cycles with valid=0.
- Owner 1 in GRANT, min_hold=10, req[3] rises at hold=7 -> no preemption until hold counter reaches 0; then grant drops, ctrl=3, grant=4'b1000 two edges later.
- Owner 0 in GRANT, enable driven to 0 -> grant=0, valid=0 at the next edge, state IDLE; requests ignored until enable=1.
- reset_n pulsed low asynchronously mid-GUARD (between edges) -> ctrl=0, grant=0, valid=0, busy=0 immediately; next arbitration starts search at index 0.
- req[2] dropped during GUARD with req[0]=1 -> guard restarts with ctrl=0; grant=4'b0001 GUARD_CYCLES edges later, never grant[2].

Source files
------------

// File: rtl/mux_arbiter.sv
// Round-robin arbiter for a shared, one-cycle registered multiplexer line.
// Drives the mux select (ctrl) and a one-hot grant. After every select change
// the line is held in GUARD for GUARD_CYCLES edges so the registered mux output
// has settled before the new owner sees valid. An owner keeps the line for at
// least min_hold+1 GRANT cycles before another requester may preempt it.
module mux_arbiter #(
    parameter int CTRL_BITS    = 2,
    parameter int NUM_REQ      = 4,
    parameter int HOLD_BITS    = 8,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [HOLD_BITS-1:0] min_hold,
    output logic [CTRL_BITS-1:0] ctrl,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 valid,
    output logic                 busy
);

    // Select space may be wider than the requester count; pad the request
    // vector so a ctrl-width index always lands inside it.
    localparam int SEL_N   = 1 << CTRL_BITS;
    localparam int GUARD_W = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    state_t                 state_reg,    state_next;
    logic [CTRL_BITS-1:0]   ctrl_reg,     ctrl_next;
    logic [NUM_REQ-1:0]     grant_reg,    grant_next;
    logic                   valid_reg,    valid_next;
    logic                   busy_reg,     busy_next;
    logic [HOLD_BITS-1:0]   hold_reg,     hold_next;
    logic [GUARD_W-1:0]     guard_reg,    guard_next;
    logic [CTRL_BITS-1:0]   last_idx_reg, last_idx_next;

    logic [NUM_REQ-1:0]     ctrl_onehot;
    logic [NUM_REQ-1:0]     own_mask;
    logic [SEL_N-1:0]       req_pad;
    logic                   owner_req;
    logic                   pick_found;
    logic [CTRL_BITS-1:0]   pick_idx;
    int                     cand_sum;

    // One-hot decode of the current select; doubles as the grant pattern.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign ctrl_onehot[gi] = (ctrl_reg == CTRL_BITS'(gi));
        end
    endgenerate

    // Outside IDLE the current select is the owner (or owner-to-be) and is
    // excluded from the search, which also places it last in its own rotation.
    assign own_mask  = (state_reg == ST_IDLE) ? '0 : ctrl_onehot;
    assign owner_req = |(req & ctrl_onehot);

    // Candidate requests, zero-extended to the full select space.
    always_comb begin
        req_pad              = '0;
        req_pad[NUM_REQ-1:0] = req & ~own_mask;
    end

    // Round-robin search starting just after the last winner.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_sum   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_sum = int'(last_idx_reg) + k;
            if (cand_sum >= NUM_REQ) begin
                cand_sum = cand_sum - NUM_REQ;
            end
            if (!pick_found && req_pad[CTRL_BITS'(cand_sum)]) begin
                pick_found = 1'b1;
                pick_idx   = CTRL_BITS'(cand_sum);
            end
        end
    end

    // Next-state and next-output logic for the IDLE/GUARD/GRANT controller.
    always_comb begin
        state_next    = state_reg;
        ctrl_next     = ctrl_reg;
        grant_next    = grant_reg;
        valid_next    = valid_reg;
        busy_next     = busy_reg;
        hold_next     = hold_reg;
        guard_next    = guard_reg;
        last_idx_next = last_idx_reg;

        case (state_reg)
            ST_IDLE: begin
                grant_next = '0;
                valid_next = 1'b0;
                busy_next  = 1'b0;
                if (enable && pick_found) begin
                    state_next    = ST_GUARD;
                    ctrl_next     = pick_idx;
                    last_idx_next = pick_idx;
                    guard_next    = GUARD_W'(GUARD_CYCLES);
                    busy_next     = 1'b1;
                end
            end

            ST_GUARD: begin
                grant_next = '0;
                valid_next = 1'b0;
                if (!owner_req || !enable) begin
                    // Pending owner vanished or arbitration disabled: abort.
                    if (enable && pick_found) begin
                        ctrl_next     = pick_idx;
                        last_idx_next = pick_idx;
                        guard_next    = GUARD_W'(GUARD_CYCLES);
                        busy_next     = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                        busy_next  = 1'b0;
                    end
                end else if (guard_reg == GUARD_W'(1)) begin
                    state_next = ST_GRANT;
                    grant_next = ctrl_onehot;
                    valid_next = 1'b1;
                    busy_next  = 1'b1;
                    hold_next  = min_hold;
                end else begin
                    guard_next = guard_reg - GUARD_W'(1);
                end
            end

            ST_GRANT: begin
                if (hold_reg != '0) begin
                    hold_next = hold_reg - HOLD_BITS'(1);
                end
                if (!owner_req || !enable || ((hold_reg == '0) && pick_found)) begin
                    // Release or preemption: the line is withdrawn at this edge.
                    grant_next = '0;
                    valid_next = 1'b0;
                    if (enable && pick_found) begin
                        state_next    = ST_GUARD;
                        ctrl_next     = pick_idx;
                        last_idx_next = pick_idx;
                        guard_next    = GUARD_W'(GUARD_CYCLES);
                        busy_next     = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                        busy_next  = 1'b0;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
                valid_next = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any guard or grant at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            ctrl_reg     <= '0;
            grant_reg    <= '0;
            valid_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            hold_reg     <= '0;
            guard_reg    <= '0;
            last_idx_reg <= CTRL_BITS'(NUM_REQ - 1);
        end else begin
            state_reg    <= state_next;
            ctrl_reg     <= ctrl_next;
            grant_reg    <= grant_next;
            valid_reg    <= valid_next;
            busy_reg     <= busy_next;
            hold_reg     <= hold_next;
            guard_reg    <= guard_next;
            last_idx_reg <= last_idx_next;
        end
    end

    assign ctrl  = ctrl_reg;
    assign grant = grant_reg;
    assign valid = valid_reg;
    assign busy  = busy_reg;

endmodule
